// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit feeding the register-file write port.
// One shift-add (multiply) or restoring (divide) step per clock over WIDTH cycles.
module mul_div_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    src_a,
  input  logic [WIDTH-1:0]    src_b,
  input  logic [REG_BITS-1:0] dest_reg,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result_lo,
  output logic [WIDTH-1:0]    result_hi,
  output logic [REG_BITS-1:0] wb_reg,
  output logic [WIDTH-1:0]    wb_data,
  output logic                wb_en
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic                is_div_q,   is_div_d;
  logic                neg_res_q,  neg_res_d;
  logic                neg_rem_q,  neg_rem_d;
  logic                div_zero_q, div_zero_d;
  logic [REG_BITS-1:0] dest_q,     dest_d;
  logic [WIDTH-1:0]    hi_q,       hi_d;
  logic [WIDTH-1:0]    lo_q,       lo_d;
  logic [WIDTH-1:0]    opnd_q,     opnd_d;
  logic [CW-1:0]       cnt_q,      cnt_d;
  logic [WIDTH-1:0]    res_lo_q,   res_lo_d;
  logic [WIDTH-1:0]    res_hi_q,   res_hi_d;
  logic [REG_BITS-1:0] wb_reg_q,   wb_reg_d;

  logic                last_step;
  logic                sign_a, sign_b;
  logic [WIDTH-1:0]    a_mag, b_mag;

  logic [WIDTH:0]      mul_sum;
  logic [WIDTH-1:0]    mul_hi, mul_lo;
  logic [WIDTH:0]      div_shift;
  logic                div_ge;
  logic [WIDTH-1:0]    div_diff;
  logic [WIDTH-1:0]    div_hi, div_lo;
  logic [WIDTH-1:0]    step_hi, step_lo;
  logic [2*WIDTH-1:0]  prod, prod_neg;
  logic [WIDTH-1:0]    fix_hi, fix_lo;

  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // Operand conditioning at issue: signed ops work on magnitudes plus sign flags.
  always_comb begin
    sign_a = op[0] & src_a[WIDTH-1];
    sign_b = op[0] & src_b[WIDTH-1];
    a_mag  = sign_a ? (~src_a + 1'b1) : src_a;
    b_mag  = sign_b ? (~src_b + 1'b1) : src_b;
  end

  // Multiply: {hi,lo} holds partial product and remaining multiplier bits.
  // Divide:   hi is the partial remainder, lo shifts dividend out / quotient in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_hi    = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ge};
    step_hi   = is_div_q ? div_hi : mul_hi;
    step_lo   = is_div_q ? div_lo : mul_lo;
  end

  // Sign fix-up on the final step; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_neg = ~prod + 1'b1;
    fix_hi   = step_hi;
    fix_lo   = step_lo;
    if (!is_div_q) begin
      if (neg_res_q) begin
        fix_hi = prod_neg[2*WIDTH-1:WIDTH];
        fix_lo = prod_neg[WIDTH-1:0];
      end
    end else begin
      if (div_zero_q) begin
        fix_lo = '1;
      end else if (neg_res_q) begin
        fix_lo = ~step_lo + 1'b1;
      end
      if (neg_rem_q) begin
        fix_hi = ~step_hi + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    wb_en = (state_q == DONE) && (wb_reg_q != '0);
  end

  always_comb begin
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    dest_d     = dest_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    wb_reg_d   = wb_reg_q;
    if (state_q == IDLE && start) begin
      is_div_d   = op[1];
      neg_res_d  = sign_a ^ sign_b;
      neg_rem_d  = sign_a;
      div_zero_d = (src_b == '0);
      dest_d     = dest_reg;
      hi_d       = '0;
      lo_d       = a_mag;
      opnd_d     = b_mag;
      cnt_d      = '0;
    end else if (state_q == RUN) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      if (last_step) begin
        res_lo_d = fix_lo;
        res_hi_d = fix_hi;
        wb_reg_d = dest_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      dest_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      wb_reg_q   <= '0;
    end else begin
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      dest_q     <= dest_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      res_lo_q   <= res_lo_d;
      res_hi_q   <= res_hi_d;
      wb_reg_q   <= wb_reg_d;
    end
  end

  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign wb_data   = res_lo_q;
  assign wb_reg    = wb_reg_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: products, quotients, boundary cases,
// start-while-busy, zero destination and asynchronous reset mid-operation.
module tb_mul_div_unit;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned REG_BITS = 5;

  logic                clk;
  logic                reset;
  logic                start;
  logic [1:0]          op;
  logic [WIDTH-1:0]    src_a;
  logic [WIDTH-1:0]    src_b;
  logic [REG_BITS-1:0] dest_reg;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    result_lo;
  logic [WIDTH-1:0]    result_hi;
  logic [REG_BITS-1:0] wb_reg;
  logic [WIDTH-1:0]    wb_data;
  logic                wb_en;

  int checks;
  int failures;

  mul_div_unit #(
    .WIDTH    (WIDTH),
    .REG_BITS (REG_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .dest_reg  (dest_reg),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .wb_en     (wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request before a rising edge, then scrambles the operands after it.
  task automatic start_op(input logic [1:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [REG_BITS-1:0] d);
    @(negedge clk);
    op       = o;
    src_a    = a;
    src_b    = b;
    dest_reg = d;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
    dest_reg = REG_BITS'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [REG_BITS-1:0] d,
                        input logic [WIDTH-1:0] exp_lo, input logic [WIDTH-1:0] exp_hi);
    int cyc;
    start_op(o, a, b, d);
    wait_done(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd32);
    check({tag, "_lo"}, 64'(result_lo), 64'(exp_lo));
    check({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
    check({tag, "_wb_data"}, 64'(wb_data), 64'(exp_lo));
    check({tag, "_wb_reg"}, 64'(wb_reg), 64'(d));
    check({tag, "_wb_en"}, 64'(wb_en), 64'(d != '0));
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    check({tag, "_wb_en_drop"}, 64'(wb_en), 64'd0);
    check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    check({tag, "_lo_hold"}, 64'(result_lo), 64'(exp_lo));
  endtask

  initial begin
    int dones;
    int wbs;
    int first;
    int cyc;
    logic [WIDTH-1:0] lo_at;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    src_a    = '0;
    src_b    = '0;
    dest_reg = '0;

    #23;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wb_en", 64'(wb_en), 64'd0);
    check("rst_lo", 64'(result_lo), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_wb_reg", 64'(wb_reg), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mul_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 5'd9, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    run_op("mul_both_neg", 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFB, 5'd4, 32'd10, 32'd0);
    run_op("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("div_7_neg2", 2'b11, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'hFFFF_FFFD, 32'd1);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 32'd0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd8, 32'd14, 32'd2);
    run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'h0001_0000, 5'd31, 32'h0000_FFFF, 32'h0000_FFFF);
    run_op("divu_by0", 2'b10, 32'd100, 32'd0, 5'd3, 32'hFFFF_FFFF, 32'd100);
    run_op("div_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Second start while busy, destination r0.
    start_op(2'b00, 32'd6, 32'd7, 5'd0);
    dones = 0;
    wbs   = 0;
    first = 0;
    lo_at = '0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin
        check("busy_midrun", 64'(busy), 64'd1);
        check("lo_hold_midrun", 64'(result_lo), 64'hFFFF_FFFF);
        check("hi_hold_midrun", 64'(result_hi), 64'hFFFF_FFFB);
        op       = 2'b00;
        src_a    = 32'd2;
        src_b    = 32'd3;
        dest_reg = 5'd5;
        start    = 1'b1;
      end
      if (c == 6) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first == 0) begin
          first = c;
          lo_at = result_lo;
        end
      end
      if (wb_en === 1'b1) wbs++;
    end
    check("ignore_done_count", 64'(dones), 64'd1);
    check("ignore_done_cycle", 64'(first), 64'd32);
    check("ignore_result", 64'(lo_at), 64'd42);
    check("r0_wb_en_count", 64'(wbs), 64'd0);

    // Asynchronous reset after ten RUN steps.
    start_op(2'b00, 32'd5, 32'd5, 5'd3);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_lo", 64'(result_lo), 64'd0);
    check("midrst_hi", 64'(result_hi), 64'd0);
    check("midrst_wb_reg", 64'(wb_reg), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    check("midrst_still_idle", 64'(busy), 64'd0);
    run_op("post_rst", 2'b00, 32'd5, 32'd5, 5'd3, 32'd25, 32'd0);

    // Throughput: a request right after the previous DONE is accepted.
    start_op(2'b01, 32'd3, 32'hFFFF_FFFF, 5'd12);
    wait_done(cyc);
    check("b2b_latency", 64'(cyc), 64'd32);
    check("b2b_lo", 64'(result_lo), 64'hFFFF_FFFD);
    check("b2b_hi", 64'(result_hi), 64'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
